// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// uart_tx_ctrl: byte FIFO feeding an 8N1 serial transmitter.
// Frames go back-to-back while the FIFO holds data; the line idles high.
module uart_tx_ctrl #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  output logic          uart_tx,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          rdy_en_q;
  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          push, pop, fifo_empty, bit_end;

  // Ready comes only from registered occupancy, so a pop in the same cycle
  // never opens a slot early; rdy_en_q holds it low until the first edge out of reset.
  assign fifo_empty = (level_q == '0);
  assign wr_ready   = rdy_en_q && (level_q != LW'(FIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  assign bit_end    = (cnt_q == '0);

  assign uart_tx    = tx_q;
  assign busy       = !((state_q == IDLE) && fifo_empty);
  assign fifo_level = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          cnt_d   = BIT_RELOAD;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          cnt_d   = BIT_RELOAD;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = BIT_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            cnt_d   = BIT_RELOAD;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 Parameter CLK_DIV, default 868, SHALL set the clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the TX FIFO entries; power of two, 2..256.
REQ-004 clk  input  1  core clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_valid  input  1  producer offers a byte on wr_data.
REQ-007 wr_data  input  8  byte to transmit.
REQ-008 wr_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 uart_tx  output  1  serial line toward the tty/host receiver; idle high.
REQ-010 busy  output  1  FIFO non-empty or frame in progress.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 A byte SHALL be accepted on a rising edge where wr_valid && wr_ready; wr_data is written to the FIFO tail.
REQ-013 wr_ready SHALL equal !full, from registered occupancy only; a same-cycle pop SHALL NOT raise wr_ready.
REQ-014 wr_valid while wr_ready=0 SHALL be ignored; nothing is written and the overflow is silent.
REQ-015 The frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), no parity.
REQ-016 Each bit SHALL last exactly CLK_DIV clk cycles, timed by a 16-bit down-counter reloaded with CLK_DIV-1 at each bit start.
REQ-017 The FSM SHALL have states IDLE, START, DATA, and STOP.
REQ-018 IDLE -> START: when the FIFO is non-empty, pop the head into the shift register and drive uart_tx=0 from the next edge.
REQ-019 START -> DATA: when the bit counter reaches 0; bit index = 0.
REQ-020 DATA: uart_tx = shift[0]; at each bit end, shift right and increment the 3-bit index; after index 7 ends, go to STOP.
REQ-021 STOP: uart_tx=1 for CLK_DIV cycles; at the end, go to START with a pop if the FIFO is non-empty (no idle cycle between frames), else go to IDLE.
REQ-022 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL make uart_tx fall at edge N+1; frame length is 10*CLK_DIV cycles.
REQ-023 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve byte order.
REQ-024 Push to an empty FIFO SHALL NOT bypass it; the pop occurs on the following edge.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full = (level == FIFO_DEPTH), empty = (level == 0).
REQ-026 uart_tx SHALL be a registered output, glitch-free.
REQ-027 busy SHALL be 0 only when state == IDLE and level == 0.

Reset
REQ-028 While rst_n=0: uart_tx=1, wr_ready=0, busy=0, fifo_level=0, state=IDLE, counters=0, pointers=0.
REQ-029 wr_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 Reset asserted mid-frame SHALL force uart_tx=1 immediately (asynchronously), discard the frame and all FIFO contents, and transmit no partial bits after release.

Verification (CLK_DIV=4, FIFO_DEPTH=4 unless noted)
REQ-031 Single byte 0xA5 pushed after reset -> uart_tx = 0, 1,0,1,0,0,1,0,1, 1, each for 4 cycles; falls 1 cycle after the accept edge; busy=0 after 40 cycles.
REQ-032 Push 0x00, 0xFF, 0x55 back-to-back -> three contiguous frames of 120 cycles total with no idle cycle between them; byte order preserved.
REQ-033 Push 6 bytes with wr_valid held high -> wr_ready=0 when level=4; stall until the first pop; all 6 bytes transmitted in order; none lost.
REQ-034 Full FIFO with pop and push in the same cycle -> push rejected (wr_ready=0); level goes 4 to 3.
REQ-035 rst_n pulsed low during DATA bit 3 -> uart_tx=1 within the pulse; FIFO empty; no further transitions until a new push.
REQ-036 Default CLK_DIV=868 -> measured bit period 8680 ns at the 100 MHz clk.
